// File: rtl/simple_processor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simple_processor_pkg
// Purpose  : Shared widths, fetch defaults and fetch FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package simple_processor_pkg;

    localparam int ADDR_WIDTH       = 16;
    localparam int DATA_WIDTH       = 16;
    localparam int INSTR_BYTES      = 2;
    localparam int FETCH_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous prefetch FIFO with push/pop/flush; head reads 0 when empty.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Handshaked IMEM fetch with prefetch FIFO and redirect/flush.
//            Optional FETCH_PERF_CNT_EN adds fetch/stall performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int ADDR_WIDTH  = simple_processor_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = simple_processor_pkg::DATA_WIDTH,
    parameter int INSTR_BYTES = simple_processor_pkg::INSTR_BYTES,
    parameter int FIFO_DEPTH  = simple_processor_pkg::FETCH_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic [ADDR_WIDTH-1:0] boot_addr_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  imem_ack_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt_o,
    output logic [31:0]           perf_stall_cnt_o
`endif
);

    import simple_processor_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] c_DEPTH = (CW+1)'(FIFO_DEPTH);

    fetch_state_t          r_state, w_state_d;
    logic                  r_req, w_req_d;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
    logic [ADDR_WIDTH-1:0] r_fetch_pc, w_pc_d;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [CW:0]           w_cnt_after;
    logic                  w_slot_after_push;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] w_head;

    assign w_pc_inc          = r_fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
    assign w_pop             = instr_valid_o & instr_ready_i;
    // Occupancy after this cycle's push/pop; a further request needs one more slot.
    assign w_cnt_after       = {1'b0, w_count} + (CW+1)'(1) - {{CW{1'b0}}, w_pop};
    assign w_slot_after_push = (w_cnt_after < c_DEPTH);

    always_comb begin
        w_state_d = r_state;
        w_req_d   = r_req;
        w_addr_d  = r_addr;
        w_pc_d    = r_fetch_pc;
        w_push    = 1'b0;
        w_flush   = 1'b0;
        if (redirect_i) begin
            w_flush = 1'b1;
            w_pc_d  = redirect_addr_i;
            if (r_req && !imem_ack_i) begin
                w_state_d = DROP;
            end else if (r_req) begin
                w_req_d   = 1'b1;
                w_addr_d  = redirect_addr_i;
                w_state_d = WAIT;
            end else begin
                w_state_d = IDLE;
            end
        end else begin
            case (r_state)
                BOOT: begin
                    w_pc_d    = boot_addr_i;
                    w_state_d = IDLE;
                end
                IDLE: begin
                    if (!w_full) begin
                        w_req_d   = 1'b1;
                        w_addr_d  = r_fetch_pc;
                        w_state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack_i) begin
                        w_push = 1'b1;
                        w_pc_d = w_pc_inc;
                        if (w_slot_after_push) begin
                            w_addr_d = w_pc_inc;
                        end else begin
                            w_req_d   = 1'b0;
                            w_state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack_i) begin
                        if (!w_full) begin
                            w_addr_d  = r_fetch_pc;
                            w_state_d = WAIT;
                        end else begin
                            w_req_d   = 1'b0;
                            w_state_d = IDLE;
                        end
                    end
                end
                default: begin
                    w_req_d   = 1'b0;
                    w_state_d = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state    <= BOOT;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_fetch_pc <= '0;
        end else begin
            r_state    <= w_state_d;
            r_req      <= w_req_d;
            r_addr     <= w_addr_d;
            r_fetch_pc <= w_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata ({r_addr, imem_rdata_i}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_addr;
    assign instr_valid_o = ~w_empty;
    assign instr_o       = w_head[DATA_WIDTH-1:0];
    assign instr_pc_o    = w_head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_push)              r_perf_fetch <= r_perf_fetch + 32'd1;
            if (r_req && !imem_ack_i) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_cnt_o = r_perf_fetch;
    assign perf_stall_cnt_o = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed vector table plus hand sequences for instr_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk_i;
    logic        arst_ni;
    logic [15:0] boot_addr_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic [15:0] imem_rdata_i;
    logic        imem_ack_i;
    logic        redirect_i;
    logic [15:0] redirect_addr_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [15:0] instr_o;
    logic [15:0] instr_pc_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_stall_cnt_o;
`endif

    instr_fetch_unit #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (16),
        .INSTR_BYTES (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_i           (clk_i),
        .arst_ni         (arst_ni),
        .boot_addr_i     (boot_addr_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rdata_i    (imem_rdata_i),
        .imem_ack_i      (imem_ack_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        ack;
        logic [15:0] rdata;
        logic        ready;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
    } vec_t;

    vec_t        tbl [9];
    int          n_err;
    int          n_checks;
    logic [15:0] exp_a;
    logic [15:0] exp_pop;

    function automatic logic [15:0] mk(input logic [15:0] a);
        return {4'hB, a[11:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] boot);
        arst_ni         = 1'b0;
        imem_ack_i      = 1'b0;
        redirect_i      = 1'b0;
        instr_ready_i   = 1'b1;
        boot_addr_i     = boot;
        cyc();
        cyc();
        arst_ni = 1'b1;
        exp_a   = boot;
        exp_pop = boot;
    endtask

    // Zero-wait memory: ack whenever a request is seen; checks pops in order.
    task automatic run_fetch(input int n);
        int got;
        got = 0;
        for (int k = 0; k < 4 * n + 8 && got < n; k++) begin
            if (instr_valid_o && instr_ready_i) begin
                chk("run_pop_pc", {16'h0, instr_pc_o}, {16'h0, exp_pop});
                chk("run_pop_instr", {16'h0, instr_o}, {16'h0, mk(exp_pop)});
                exp_pop = exp_pop + 16'd2;
            end
            if (imem_req_o) begin
                chk("run_addr", {16'h0, imem_addr_o}, {16'h0, exp_a});
                imem_ack_i   = 1'b1;
                imem_rdata_i = mk(exp_a);
                exp_a        = exp_a + 16'd2;
                got++;
            end else begin
                imem_ack_i = 1'b0;
            end
            cyc();
        end
        imem_ack_i = 1'b0;
        chk("run_fetch_budget", got, n);
    endtask

    task automatic wait_req();
        for (int k = 0; k < 8 && !imem_req_o; k++) cyc();
        chk("wait_req_budget", {31'h0, imem_req_o}, 32'd1);
    endtask

    initial begin
        int n_ack;
        int pops;
        n_err    = 0;
        n_checks = 0;

        //             ack   rdata     rdy   req   addr      vld   instr     pc
        tbl[0] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000};
        tbl[3] = '{1'b1, 16'hB100, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000};
        tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0102, 1'b1, 16'hB100, 16'h0100};
        tbl[5] = '{1'b1, 16'hB102, 1'b1, 1'b1, 16'h0102, 1'b0, 16'h0000, 16'h0000};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0104, 1'b1, 16'hB102, 16'h0102};
        tbl[7] = '{1'b1, 16'hB104, 1'b1, 1'b1, 16'h0104, 1'b0, 16'h0000, 16'h0000};
        tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0106, 1'b1, 16'hB104, 16'h0104};

        arst_ni         = 1'b0;
        boot_addr_i     = 16'h0100;
        imem_ack_i      = 1'b0;
        imem_rdata_i    = 16'h0000;
        redirect_i      = 1'b0;
        redirect_addr_i = 16'h0000;
        instr_ready_i   = 1'b1;
        cyc();
        chk("rst_req",   {31'h0, imem_req_o},    32'd0);
        chk("rst_addr",  {16'h0, imem_addr_o},   32'd0);
        chk("rst_valid", {31'h0, instr_valid_o}, 32'd0);
        chk("rst_instr", {16'h0, instr_o},       32'd0);
        chk("rst_pc",    {16'h0, instr_pc_o},    32'd0);
        cyc();
        arst_ni = 1'b1;

        // Boot at 0x0100 with one wait cycle per fetch, decoder always ready.
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t1_req[%0d]", i),   {31'h0, imem_req_o},    {31'h0, tbl[i].e_req});
            chk($sformatf("t1_addr[%0d]", i),  {16'h0, imem_addr_o},   {16'h0, tbl[i].e_addr});
            chk($sformatf("t1_valid[%0d]", i), {31'h0, instr_valid_o}, {31'h0, tbl[i].e_valid});
            chk($sformatf("t1_instr[%0d]", i), {16'h0, instr_o},       {16'h0, tbl[i].e_instr});
            chk($sformatf("t1_pc[%0d]", i),    {16'h0, instr_pc_o},    {16'h0, tbl[i].e_pc});
            imem_ack_i    = tbl[i].ack;
            imem_rdata_i  = tbl[i].rdata;
            instr_ready_i = tbl[i].ready;
            cyc();
        end
        imem_ack_i = 1'b0;

        // Decoder stalled: exactly FIFO_DEPTH pushes, then request drops.
        exp_a         = 16'h0106;
        instr_ready_i = 1'b0;
        n_ack         = 0;
        for (int k = 0; k < 8; k++) begin
            if (imem_req_o) begin
                chk("t2_addr", {16'h0, imem_addr_o}, {16'h0, exp_a});
                imem_ack_i   = 1'b1;
                imem_rdata_i = mk(exp_a);
                exp_a        = exp_a + 16'd2;
                n_ack++;
            end else begin
                imem_ack_i = 1'b0;
            end
            cyc();
        end
        imem_ack_i = 1'b0;
        chk("t2_pushes",  n_ack, 4);
        chk("t2_req_low", {31'h0, imem_req_o},    32'd0);
        chk("t2_valid",   {31'h0, instr_valid_o}, 32'd1);
        chk("t2_head_pc", {16'h0, instr_pc_o},    32'h0106);

        instr_ready_i = 1'b1;
        exp_pop       = 16'h0106;
        pops          = 0;
        for (int k = 0; k < 30 && pops < 6; k++) begin
            if (instr_valid_o) begin
                chk("t2_pop_pc",    {16'h0, instr_pc_o}, {16'h0, exp_pop});
                chk("t2_pop_instr", {16'h0, instr_o},    {16'h0, mk(exp_pop)});
                exp_pop = exp_pop + 16'd2;
                pops++;
            end
            if (imem_req_o) begin
                chk("t2_resume_addr", {16'h0, imem_addr_o}, {16'h0, exp_a});
                imem_ack_i   = 1'b1;
                imem_rdata_i = mk(exp_a);
                exp_a        = exp_a + 16'd2;
            end else begin
                imem_ack_i = 1'b0;
            end
            cyc();
        end
        imem_ack_i = 1'b0;
        chk("t2_drain_budget", pops, 6);

        // Redirect while the request to 0x0106 is outstanding; ack arrives late.
        do_reset(16'h0100);
        run_fetch(3);
        chk("t3_out_req",  {31'h0, imem_req_o},  32'd1);
        chk("t3_out_addr", {16'h0, imem_addr_o}, 32'h0106);
        redirect_i      = 1'b1;
        redirect_addr_i = 16'h0400;
        cyc();
        redirect_i = 1'b0;
        chk("t3_flush_valid", {31'h0, instr_valid_o}, 32'd0);
        chk("t3_hold_addr1",  {16'h0, imem_addr_o},   32'h0106);
        cyc();
        chk("t3_hold_req2",   {31'h0, imem_req_o},    32'd1);
        chk("t3_hold_addr2",  {16'h0, imem_addr_o},   32'h0106);
        imem_ack_i   = 1'b1;
        imem_rdata_i = 16'hDEAD;
        cyc();
        imem_ack_i = 1'b0;
        chk("t3_drop_valid", {31'h0, instr_valid_o}, 32'd0);
        chk("t3_new_req",    {31'h0, imem_req_o},    32'd1);
        chk("t3_new_addr",   {16'h0, imem_addr_o},   32'h0400);
        imem_ack_i   = 1'b1;
        imem_rdata_i = mk(16'h0400);
        cyc();
        imem_ack_i = 1'b0;
        chk("t3_pc",    {16'h0, instr_pc_o},  32'h0400);
        chk("t3_instr", {16'h0, instr_o},     {16'h0, mk(16'h0400)});
        chk("t3_next",  {16'h0, imem_addr_o}, 32'h0402);

        // Redirect in the same cycle as the ack of 0x0402.
        imem_ack_i      = 1'b1;
        imem_rdata_i    = 16'hBAD0;
        redirect_i      = 1'b1;
        redirect_addr_i = 16'h0800;
        cyc();
        imem_ack_i = 1'b0;
        redirect_i = 1'b0;
        chk("t4_valid", {31'h0, instr_valid_o}, 32'd0);
        chk("t4_req",   {31'h0, imem_req_o},    32'd1);
        chk("t4_addr",  {16'h0, imem_addr_o},   32'h0800);
        imem_ack_i   = 1'b1;
        imem_rdata_i = mk(16'h0800);
        cyc();
        imem_ack_i = 1'b0;
        chk("t4_pc",    {16'h0, instr_pc_o}, 32'h0800);
        chk("t4_instr", {16'h0, instr_o},    {16'h0, mk(16'h0800)});
        cyc();
        chk("t4_no_stale", {31'h0, instr_valid_o}, 32'd0);

        // PC wrap at 0xFFFE, then reset pulsed while waiting for an ack.
        imem_ack_i      = 1'b1;
        imem_rdata_i    = 16'hBAD1;
        redirect_i      = 1'b1;
        redirect_addr_i = 16'hFFFE;
        cyc();
        redirect_i = 1'b0;
        chk("t5_addr_fffe", {16'h0, imem_addr_o}, 32'hFFFE);
        imem_rdata_i = mk(16'hFFFE);
        cyc();
        imem_ack_i = 1'b0;
        chk("t5_wrap_addr", {16'h0, imem_addr_o}, 32'h0000);
        chk("t5_wrap_req",  {31'h0, imem_req_o},  32'd1);
        chk("t5_pc_fffe",   {16'h0, instr_pc_o},  32'hFFFE);
        arst_ni = 1'b0;
        #2;
        chk("t5_rst_req",   {31'h0, imem_req_o},    32'd0);
        chk("t5_rst_addr",  {16'h0, imem_addr_o},   32'd0);
        chk("t5_rst_valid", {31'h0, instr_valid_o}, 32'd0);
        chk("t5_rst_instr", {16'h0, instr_o},       32'd0);
        chk("t5_rst_pc",    {16'h0, instr_pc_o},    32'd0);
        cyc();
        arst_ni      = 1'b1;
        boot_addr_i  = 16'h0200;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 16'hBAD2;
        cyc();
        imem_ack_i = 1'b0;
        chk("t5_stale_ack_req",   {31'h0, imem_req_o},    32'd0);
        chk("t5_stale_ack_valid", {31'h0, instr_valid_o}, 32'd0);
        cyc();
        chk("t5_boot_req",  {31'h0, imem_req_o},  32'd1);
        chk("t5_boot_addr", {16'h0, imem_addr_o}, 32'h0200);

`ifdef FETCH_PERF_CNT_EN
        // Five fetches with two wait cycles each.
        do_reset(16'h0300);
        chk("t6_rst_fetch", perf_fetch_cnt_o, 32'd0);
        chk("t6_rst_stall", perf_stall_cnt_o, 32'd0);
        for (int f = 0; f < 5; f++) begin
            wait_req();
            imem_ack_i = 1'b0;
            cyc();
            cyc();
            imem_ack_i   = 1'b1;
            imem_rdata_i = mk(imem_addr_o);
            cyc();
            imem_ack_i = 1'b0;
        end
        chk("t6_fetch_cnt", perf_fetch_cnt_o, 32'd5);
        chk("t6_stall_cnt", perf_stall_cnt_o, 32'd10);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
